fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 108 ++++++++++
 tb/tb_fetch_unit.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch/issue sequencer: fetches one word per instruction, holds
// the decoded fields until the ALU stage accepts them, and resolves jumps and beq.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [5:0]  BEQ_OP   = 6'h04,
  parameter logic [5:0]  J_OP     = 6'h02
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        issue_valid,
  input  logic        issue_ready,
  output logic [5:0]  opcode,
  output logic [5:0]  func_field,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [15:0] imm,
  output logic [31:0] pc_out,
  input  logic        br_valid,
  input  logic        br_taken
);

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    ISSUE   = 2'd1,
    RESOLVE = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] ir;
  logic [31:0] jump_target;
  logic [31:0] br_offset;

  // pc already points past the jump/branch when these are consumed.
  assign jump_target = {pc[31:28], ir[25:0], 2'b00};
  assign br_offset   = {{14{ir[15]}}, ir[15:0], 2'b00};

  assign imem_addr  = pc;
  assign opcode     = ir[31:26];
  assign rs         = ir[25:21];
  assign rt         = ir[20:16];
  assign rd         = ir[15:11];
  assign imm        = ir[15:0];
  assign func_field = ir[5:0];

  // imem_req is registered, so the first FETCH cycle after reset only raises it;
  // an ack is honoured only while the request is actually visible.
  // NOTE: all state uses non-blocking assignments so every register samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      ir          <= 32'h0;
      pc_out      <= 32'h0;
      imem_req    <= 1'b0;
      issue_valid <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          if (imem_req && imem_ack) begin
            ir          <= imem_rdata;
            pc_out      <= pc;
            pc          <= pc + 32'd4;
            imem_req    <= 1'b0;
            issue_valid <= 1'b1;
            state       <= ISSUE;
          end else begin
            imem_req <= 1'b1;
          end
        end
        ISSUE: begin
          if (issue_ready) begin
            issue_valid <= 1'b0;
            if (opcode == J_OP) begin
              pc       <= jump_target;
              imem_req <= 1'b1;
              state    <= FETCH;
            end else if (opcode == BEQ_OP) begin
              state <= RESOLVE;
            end else begin
              imem_req <= 1'b1;
              state    <= FETCH;
            end
          end
        end
        RESOLVE: begin
          if (br_valid) begin
            if (br_taken) pc <= pc + br_offset;
            imem_req <= 1'b1;
            state    <= FETCH;
          end
        end
        default: begin
          imem_req    <= 1'b0;
          issue_valid <= 1'b0;
          state       <= FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: sequential fetch/issue, stalls, jumps, beq
// taken/not-taken/backward, PC wrap, and asynchronous reset mid-ISSUE.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        issue_ready, br_valid, br_taken;

  logic        imem_req, imem_ack, issue_valid;
  logic [31:0] imem_addr, imem_rdata, pc_out;
  logic [5:0]  opcode, func_field;
  logic [4:0]  rs, rt, rd;
  logic [15:0] imm;

  logic        imem_req2, imem_ack2, issue_valid2;
  logic [31:0] imem_addr2, imem_rdata2, pc_out2;
  logic [5:0]  opcode2, func_field2;
  logic [4:0]  rs2, rt2, rd2;
  logic [15:0] imm2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fetch_unit u_dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .opcode(opcode), .func_field(func_field), .rs(rs), .rt(rt), .rd(rd), .imm(imm),
    .pc_out(pc_out), .br_valid(br_valid), .br_taken(br_taken)
  );

  // Second instance starts just below a 256 MB region to exercise jump upper bits.
  fetch_unit #(.RESET_PC(32'h0FFF_FFFC)) u_hi (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req2), .imem_addr(imem_addr2), .imem_ack(imem_ack2), .imem_rdata(imem_rdata2),
    .issue_valid(issue_valid2), .issue_ready(issue_ready),
    .opcode(opcode2), .func_field(func_field2), .rs(rs2), .rt(rt2), .rd(rd2), .imm(imm2),
    .pc_out(pc_out2), .br_valid(br_valid), .br_taken(br_taken)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Fetch one word on the selected instance and hand it straight to the ALU.
  task automatic fetch_issue(input bit hi, input logic [31:0] instr);
    if (hi) begin imem_ack2 = 1'b1; imem_rdata2 = instr; end
    else    begin imem_ack  = 1'b1; imem_rdata  = instr; end
    step();
    imem_ack    = 1'b0;
    imem_ack2   = 1'b0;
    issue_ready = 1'b1;
    step();
    issue_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; issue_ready = 1'b0; br_valid = 1'b0; br_taken = 1'b0;
    imem_ack = 1'b0; imem_rdata = 32'h0; imem_ack2 = 1'b0; imem_rdata2 = 32'h0;

    #12;
    check("rst_req",    imem_req,    1'b0);
    check("rst_valid",  issue_valid, 1'b0);
    check("rst_pc_out", pc_out,      32'h0);
    check("rst_ir",     {opcode, rs, rt, imm}, 32'h0);

    @(negedge clk) rst_n = 1'b1;
    step();
    check("boot_req",  imem_req,  1'b1);
    check("boot_addr", imem_addr, 32'h0);

    // add r3,r1,r2 at PC 0
    imem_ack = 1'b1; imem_rdata = 32'h0022_1820; issue_ready = 1'b1;
    step();
    imem_ack = 1'b0;
    check("add_valid",  issue_valid, 1'b1);
    check("add_req",    imem_req,    1'b0);
    check("add_opcode", opcode,      6'h00);
    check("add_func",   func_field,  6'h20);
    check("add_rs",     rs,          5'd1);
    check("add_rt",     rt,          5'd2);
    check("add_rd",     rd,          5'd3);
    check("add_pc_out", pc_out,      32'h0);
    step();
    issue_ready = 1'b0;
    check("add_next_req",  imem_req,  1'b1);
    check("add_next_addr", imem_addr, 32'h4);

    // sub at PC 4 held by a 5-cycle stall; a stray ack must not reload IR
    imem_ack = 1'b1; imem_rdata = 32'h0128_5022;
    step();
    imem_rdata = 32'hFFFF_FFFF;
    for (int i = 0; i < 5; i++) begin
      step();
      check("stall_valid", issue_valid, 1'b1);
      check("stall_req",   imem_req,    1'b0);
      check("stall_ir",    {opcode, rs, rt, rd, func_field}, {6'h00, 5'd9, 5'd8, 5'd10, 6'h22});
    end
    check("stall_pc_out", pc_out, 32'h4);
    imem_ack = 1'b0; issue_ready = 1'b1;
    step();
    issue_ready = 1'b0;
    check("stall_next_addr", imem_addr, 32'h8);

    // beq +3 at PC 8, taken -> 24
    fetch_issue(1'b0, 32'h1000_0003);
    check("beq_res_valid", issue_valid, 1'b0);
    check("beq_res_req",   imem_req,    1'b0);
    step();
    check("beq_wait_req",  imem_req,    1'b0);
    br_valid = 1'b1; br_taken = 1'b1;
    step();
    br_valid = 1'b0;
    check("beq_taken_addr", imem_addr, 32'd24);
    check("beq_taken_req",  imem_req,  1'b1);

    // j 8, then beq +3 not taken -> 12
    fetch_issue(1'b0, 32'h0800_0002);
    check("j8_addr", imem_addr, 32'd8);
    fetch_issue(1'b0, 32'h1000_0003);
    br_valid = 1'b1; br_taken = 1'b0;
    step();
    br_valid = 1'b0;
    check("beq_nt_addr", imem_addr, 32'd12);

    // j 16, then beq -1 taken loops back to 16
    fetch_issue(1'b0, 32'h0800_0004);
    check("j16_addr", imem_addr, 32'd16);
    fetch_issue(1'b0, 32'h1000_FFFF);
    br_valid = 1'b1; br_taken = 1'b1;
    step();
    check("beq_back_addr", imem_addr, 32'd16);
    // br_valid left high in FETCH must not move the PC
    step();
    br_valid = 1'b0;
    check("br_ignored_addr", imem_addr, 32'd16);
    check("br_ignored_req",  imem_req,  1'b1);

    // asynchronous reset while in ISSUE
    imem_ack = 1'b1; imem_rdata = 32'h0000_0000;
    step();
    imem_ack = 1'b0;
    check("pre_rst_valid", issue_valid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_valid", issue_valid, 1'b0);
    check("async_rst_req",   imem_req,    1'b0);
    @(negedge clk) rst_n = 1'b1;
    step();
    check("restart_req",  imem_req,  1'b1);
    check("restart_addr", imem_addr, 32'h0);

    // beq -2 taken at PC 0 -> FFFF_FFFC, then sequential wrap to 0
    fetch_issue(1'b0, 32'h1000_FFFE);
    br_valid = 1'b1; br_taken = 1'b1;
    step();
    br_valid = 1'b0;
    check("beq_wrap_addr", imem_addr, 32'hFFFF_FFFC);
    fetch_issue(1'b0, 32'h0000_0000);
    check("pc_wrap_addr", imem_addr, 32'h0);

    // upper instance: nop at 0FFF_FFFC, then j 0x40 at 1000_0000
    check("hi_boot_addr", imem_addr2, 32'h0FFF_FFFC);
    fetch_issue(1'b1, 32'h0000_0000);
    check("hi_seq_addr", imem_addr2, 32'h1000_0000);
    fetch_issue(1'b1, 32'h0800_0040);
    check("hi_jump_addr", imem_addr2, 32'h1000_0100);
    check("hi_pc_out",    pc_out2,    32'h1000_0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
